// File: rtl/mrt_poly_unpack.sv
// mrt_poly_unpack: converts one redundant-form polynomial from the MinRoot
// engine into its canonical NumBits-wide integer and streams it to the host
// as OutWords 32-bit words, least significant word first.
//
// Build option: define MRT_POLY_UNPACK_REDUCE_EN to add a REDUCE cycle that
// performs one conditional subtraction of mrt_pkg::Modulus before emitting.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   polynomial handshake (in_ready high only in IDLE)
//   in_poly               redundant polynomial, NumCoeffs x CoeffBits
//   out_valid / out_ready output word handshake
//   out_data              current 32-bit word
//   out_last              marks word OutWords-1
//   out_ovf               set bits above NumBits were dropped
//   busy                  block is not idle

package mrt_pkg;
  localparam int NumCoeffs = 17;
  localparam int WordBits  = 16;
  localparam int CoeffBits = 18;
  localparam int NumBits   = 256;
  localparam logic [NumBits-1:0] Modulus =
    256'h40000000000000000000000000000000224698fc094cf91b992d30ed00000001;
  typedef logic [NumCoeffs-1:0][CoeffBits-1:0] poly_t;
endpackage

module mrt_poly_unpack #(
  parameter int NumCoeffs = mrt_pkg::NumCoeffs,
  parameter int WordBits  = mrt_pkg::WordBits,
  parameter int CoeffBits = mrt_pkg::CoeffBits,
  parameter int NumBits   = mrt_pkg::NumBits,
  parameter int OutWords  = 10
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NumCoeffs-1:0][CoeffBits-1:0]  in_poly,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [31:0]                          out_data,
  output logic                                 out_last,
  output logic                                 out_ovf,
  output logic                                 busy
);

  localparam int AccBits   = OutWords * 32;
  localparam int CarryBits = CoeffBits + 1 - WordBits;
  localparam int IdxBits   = (NumCoeffs > 1) ? $clog2(NumCoeffs) : 1;
  localparam int WIdxBits  = (OutWords > 1) ? $clog2(OutWords) : 1;
  // Wide enough to hold the top coefficient field plus the final carry.
  localparam int ExtBits   = NumBits + (NumCoeffs + 1) * WordBits + CoeffBits;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
`ifdef MRT_POLY_UNPACK_REDUCE_EN
    REDUCE,
`endif
    EMIT
  } state_t;

  state_t                               state;
  logic [NumCoeffs-1:0][CoeffBits-1:0]  poly_q;
  logic [AccBits-1:0]                   acc;
  logic [CarryBits-1:0]                 carry;
  logic [IdxBits-1:0]                   idx;
  logic [WIdxBits-1:0]                  widx;

  logic [CoeffBits:0]    sum;
  logic [CarryBits-1:0]  carry_next;
  logic [31:0]           shift_lo;
  logic [31:0]           shift_hi;
  logic [ExtBits-1:0]    ext;
  logic [NumBits-1:0]    acc_conv;
  logic                  ovf_conv;
  logic                  last_coeff;

  // Each coefficient's low field lands in a disjoint, still-zero slice of the
  // accumulator, so an OR deposits it. Anything at or above NumBits (including
  // the final carry after the last coefficient) only feeds the overflow flag.
  always_comb begin
    sum        = {1'b0, poly_q[idx]} + (CoeffBits + 1)'(carry);
    carry_next = sum[CoeffBits:WordBits];
    last_coeff = (idx == IdxBits'(NumCoeffs - 1));
    shift_lo   = 32'(idx) * 32'(WordBits);
    shift_hi   = shift_lo + 32'(WordBits);
    ext        = ExtBits'(sum[WordBits-1:0]) << shift_lo;
    if (last_coeff) begin
      ext = ext | (ExtBits'(carry_next) << shift_hi);
    end
    acc_conv = acc[NumBits-1:0] | ext[NumBits-1:0];
    ovf_conv = |ext[ExtBits-1:NumBits];
  end

`ifdef MRT_POLY_UNPACK_REDUCE_EN
  localparam logic [NumBits-1:0] Mod = NumBits'(mrt_pkg::Modulus);
  logic [NumBits-1:0] acc_red;

  always_comb begin
    acc_red = acc[NumBits-1:0];
    if (acc[NumBits-1:0] >= Mod) begin
      acc_red = acc[NumBits-1:0] - Mod;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      poly_q    <= '0;
      acc       <= '0;
      carry     <= '0;
      idx       <= '0;
      widx      <= '0;
      out_ovf   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            poly_q   <= in_poly;
            acc      <= '0;
            carry    <= '0;
            idx      <= '0;
            out_ovf  <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          acc     <= AccBits'(acc_conv);
          carry   <= carry_next;
          out_ovf <= out_ovf | ovf_conv;
          if (last_coeff) begin
`ifdef MRT_POLY_UNPACK_REDUCE_EN
            state <= REDUCE;
`else
            state     <= EMIT;
            widx      <= '0;
            out_valid <= 1'b1;
            out_last  <= (OutWords == 1);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
`ifdef MRT_POLY_UNPACK_REDUCE_EN
        REDUCE: begin
          acc       <= AccBits'(acc_red);
          state     <= EMIT;
          widx      <= '0;
          out_valid <= 1'b1;
          out_last  <= (OutWords == 1);
        end
`endif
        EMIT: begin
          if (out_ready) begin
            if (widx == WIdxBits'(OutWords - 1)) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              widx     <= widx + 1'b1;
              out_last <= (widx == WIdxBits'(OutWords - 2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Word select straight from registered state; forced to zero outside EMIT.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      out_data = acc[32'(widx) * 32 +: 32];
    end
  end

endmodule

// File: tb/tb_mrt_poly_unpack.sv
// Self-checking bench for mrt_poly_unpack: constant-expectation vector table,
// hand-written reset/abort sequence, and randomized polynomials checked
// against an arithmetic reference model.
module tb_mrt_poly_unpack;

  localparam int NC = mrt_pkg::NumCoeffs;
  localparam int WB = mrt_pkg::WordBits;
  localparam int CB = mrt_pkg::CoeffBits;
  localparam int NB = mrt_pkg::NumBits;
  localparam int OW = 10;
  localparam int AW = OW * 32;
`ifdef MRT_POLY_UNPACK_REDUCE_EN
  localparam int LAT = NC + 1;
`else
  localparam int LAT = NC;
`endif

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  mrt_pkg::poly_t    in_poly;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic              out_last;
  logic              out_ovf;
  logic              busy;

  mrt_poly_unpack #(.OutWords(OW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_poly   (in_poly),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain weighted sum, truncate, optional single subtraction.
  function automatic logic [AW-1:0] model(input mrt_pkg::poly_t p, output logic ovf);
    logic [511:0] s;
    s = '0;
    for (int i = 0; i < NC; i++) s = s + (512'(p[i]) << (i * WB));
    ovf = |(s >> NB);
    s = s & ((512'(1) << NB) - 512'(1));
`ifdef MRT_POLY_UNPACK_REDUCE_EN
    if (s >= 512'(mrt_pkg::Modulus)) s = s - 512'(mrt_pkg::Modulus);
`endif
    return AW'(s);
  endfunction

  // mode: 0 = always ready, 1 = 3-cycle stall on word 4, 2 = random ready
  task automatic run_txn(input string name, input mrt_pkg::poly_t p,
                         input logic [AW-1:0] exp_val, input logic exp_ovf,
                         input int mode, input int abort_at, input bit junk);
    int n;
    int lat;
    int w;
    int stall;
    int guard;
    logic rdy;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk({name, " in_ready before send"}, 32'(in_ready), 32'd1);
    in_poly  = p;
    in_valid = 1'b1;
    @(posedge clk); #1;
    if (junk) in_poly = ~p;
    else in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk({name, " latency"}, 32'(lat), 32'(LAT));
    w = 0; stall = 0; guard = 0;
    while (w < OW && guard < 400) begin
      if (abort_at >= 0 && w == abort_at) break;
      chk($sformatf("%s out_valid w%0d", name, w), 32'(out_valid), 32'd1);
      chk($sformatf("%s data w%0d", name, w), out_data, exp_val[w*32 +: 32]);
      chk($sformatf("%s last w%0d", name, w), 32'(out_last), 32'(w == OW - 1));
      chk($sformatf("%s ovf w%0d", name, w), 32'(out_ovf), 32'(exp_ovf));
      case (mode)
        1: rdy = !(w == 4 && stall < 3);
        2: rdy = ($urandom_range(0, 2) != 0);
        default: rdy = 1'b1;
      endcase
      if (!rdy) stall++;
      out_ready = rdy;
      @(posedge clk); #1;
      guard++;
      if (rdy) w++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (abort_at < 0) begin
      chk({name, " words received"}, 32'(w), 32'(OW));
      chk({name, " in_ready after last"}, 32'(in_ready), 32'd1);
      chk({name, " out_valid after last"}, 32'(out_valid), 32'd0);
      chk({name, " busy after last"}, 32'(busy), 32'd0);
    end
    if (mode == 1) chk({name, " stall cycles"}, 32'(stall), 32'd3);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, " in_ready"}, 32'(in_ready), 32'd1);
    chk({name, " out_valid"}, 32'(out_valid), 32'd0);
    chk({name, " out_data"}, out_data, 32'd0);
    chk({name, " out_last"}, 32'(out_last), 32'd0);
    chk({name, " out_ovf"}, 32'(out_ovf), 32'd0);
    chk({name, " busy"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    string           name;
    mrt_pkg::poly_t  poly;
    logic [AW-1:0]   exp_val;
    logic            exp_ovf;
    int              mode;
    bit              junk;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    mrt_pkg::poly_t p;
    logic [511:0]   mp3;
    logic [AW-1:0]  ev;
    logic           eo;

    reset = 1'b1; in_valid = 1'b0; in_poly = '0; out_ready = 1'b0;

    // Vector table: expected values are written directly from the rules.
    p = '0;
    vecs[0] = '{"zero", p, '0, 1'b0, 0, 1'b0};

    p = '0;
    p[0] = CB'((1 << WB) + 5);
    p[1] = CB'((1 << WB) - 1);
    ev = AW'(5) | (AW'(1) << (2 * WB));
    vecs[1] = '{"carry", p, ev, 1'b0, 0, 1'b0};
    vecs[2] = '{"backpressure", p, ev, 1'b0, 1, 1'b0};
    vecs[3] = '{"busy_ignore", p, ev, 1'b0, 0, 1'b1};

    p = '0;
    p[NC-1] = '1;
    p[0] = CB'(7);
    vecs[4] = '{"overflow", p, AW'(7), 1'b1, 0, 1'b0};

    mp3 = 512'(mrt_pkg::Modulus) + 512'd3;
    p = '0;
    for (int i = 0; i < NC; i++) p[i] = CB'((mp3 >> (i * WB)) & ((512'(1) << WB) - 512'(1)));
`ifdef MRT_POLY_UNPACK_REDUCE_EN
    ev = AW'(3);
`else
    ev = AW'(mp3);
`endif
    vecs[5] = '{"modulus_plus_3", p, ev, 1'b0, 0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b0;

    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("idle in_ready c%0d", c), 32'(in_ready), 32'd1);
      chk($sformatf("idle out_valid c%0d", c), 32'(out_valid), 32'd0);
      chk($sformatf("idle busy c%0d", c), 32'(busy), 32'd0);
    end

    for (int v = 0; v < 6; v++) begin
      run_txn(vecs[v].name, vecs[v].poly, vecs[v].exp_val, vecs[v].exp_ovf,
              vecs[v].mode, -1, vecs[v].junk);
    end

    // Reset while word 6 is presented, then a fresh conversion.
    for (int i = 0; i < NC; i++) p[i] = CB'($urandom_range(0, (1 << CB) - 1));
    p[NC-1] = CB'(1 << (CB - 1));
    ev = model(p, eo);
    run_txn("abort", p, ev, eo, 0, 6, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("mid_emit_reset");
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post_reset out_valid c%0d", c), 32'(out_valid), 32'd0);
    end
    for (int i = 0; i < NC; i++) p[i] = CB'($urandom_range(0, (1 << CB) - 1));
    ev = model(p, eo);
    run_txn("after_reset", p, ev, eo, 0, -1, 1'b0);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NC; i++) p[i] = CB'($urandom_range(0, (1 << CB) - 1));
      if (r % 2 == 0) p[NC-1] = '0;
      ev = model(p, eo);
      run_txn($sformatf("rand%0d", r), p, ev, eo, 2, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
